mcp3202_responder: RTL and testbench
====================================

Name: mcp3202_responder

Overview:
- Synchronous SPI slave that emulates an MCP3202 12-bit dual-channel ADC on the adc_cs/adc_clk/adc_mosi/adc_miso link.
- Gives the ADC master and the audio path a deterministic sample source, so the audio path can be brought up and regressed without the physical ADC.
- Oversamples SCK, CS and MOSI in the single system clock, decodes the 4-bit command, and shifts back the selected channel's 12-bit conversion.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each of spi_sck, spi_cs_n and spi_mosi (min 2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock from the master; asynchronous to clk.
- spi_cs_n  in  1  chip select, active low; asynchronous.
- spi_mosi  in  1  command data from the master; asynchronous.
- spi_miso  out  1  response data to the master.
- spi_miso_oe  out  1  high while spi_miso is actively driven (Hi-Z request to the pad).
- ch0_sample  in  12  channel 0 value (unsigned).
- ch1_sample  in  12  channel 1 value (unsigned).
- conv_done  out  1  1-cycle pulse after B0 of the MSB-first field has been shifted out.
- last_cfg  out  3  {SGL, ODD, MSBF} of the most recent decoded command.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, conv_done=0, last_cfg=3'b000, state=IDLE.
- Synchronisation and edges:
  - Each input passes through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one further registered copy.
  - sck_rise/sck_fall are valid only while the synced cs_n is low.
- Latency: spi_miso changes on the clk cycle after sck_fall is detected, i.e. SYNC_STAGES+2 clk cycles after the pin edge.
- Master constraint: SCK high and low times are each ≥ SYNC_STAGES+3 clk cycles.
- Chip select:
  - A synced cs_n falling edge moves the FSM to WAIT_START.
  - Synced cs_n high at any time forces IDLE, spi_miso_oe=0 and spi_miso=0 on the next cycle, including mid-transfer. No conv_done is produced for an aborted transfer.
- FSM (MOSI is sampled on sck_rise; MISO is updated on sck_fall):
  - IDLE: wait for cs_n low.
  - WAIT_START: MOSI=0 is ignored (leading zeros allowed). MOSI=1 → CFG with bit count 0.
  - CFG: captures SGL, ODD, MSBF on three consecutive rises. On the 3rd rise, update last_cfg and latch the conversion value (below) → NULL.
  - NULL: on the next fall, spi_miso_oe=1 and spi_miso=0 → MSB_OUT with idx=11.
  - MSB_OUT: on each fall, drive conv[idx] and decrement idx. After conv[0] has been driven, the next fall does one of the following:
    - MSBF=1: set spi_miso_oe=0 and pulse conv_done → DONE.
    - MSBF=0: pulse conv_done → LSB_OUT (see Optional Feature).
  - LSB_OUT: on each fall, drive conv[1] up to conv[11] in that order. The fall after conv[11] sets spi_miso_oe=0 → DONE.
  - DONE: spi_miso=0; stay here until cs_n goes high.
- Conversion value, latched once per command so later input changes do not affect the frame:
  - SGL=1, ODD=0: ch0_sample.
  - SGL=1, ODD=1: ch1_sample.
  - SGL=0, ODD=0: ch0−ch1, computed in 13 bits, clamped to 0 if negative.
  - SGL=0, ODD=1: ch1−ch0, computed in 13 bits, clamped to 0 if negative.
- Simultaneous events: a cs_n rise in the same cycle as a detected SCK edge takes priority, and the edge is ignored.
- Extra SCK edges in DONE are ignored, and spi_miso stays 0.

Optional Feature:
- Macro: MCP3202_LSBF_EN.
- Defined: with MSBF=0, the LSB-first tail (B1..B11) is shifted out as described in LSB_OUT.
- Not defined: MSBF=0 behaves exactly as MSBF=1; after B0, spi_miso_oe=0 → DONE. LSB_OUT logic is absent.

Test Plan:
- Single-ended CH0: ch0=12'hA5C, command 1,1,0,1 with no leading zeros, SCK = 32 clk period.
  → MISO after the null bit reads 1010_0101_1100; conv_done pulses once; last_cfg=3'b101; spi_miso_oe drops after B0.
- Leading zeros plus CH1: three 0s before the start bit, ch1=12'h001, command 1,1,1,1.
  → Reads 12'h001; last_cfg=3'b111.
- Differential clamp: ch0=12'h100, ch1=12'h300, SGL=0, ODD=0 → reads 12'h000. ODD=1 → reads 12'h200.
- LSB-first (MCP3202_LSBF_EN defined): ch0=12'h801, MSBF=0.
  → 23 data bits after the null bit: 1000_0000_0001 then 00000000001 (B1..B11). Without the macro: 12 bits only, then spi_miso_oe=0.
- Abort: cs_n raised after 5 data bits.
  → spi_miso_oe=0 within SYNC_STAGES+2 cycles; no conv_done. The next full command returns the correct value.
- Async reset asserted mid-frame → all outputs return to reset values immediately; after release, the FSM stays in IDLE until a fresh cs_n fall.

Source files
------------

// File: rtl/mcp3202_responder_if.sv
// rtl/mcp3202_responder_if.sv - SPI pin bundle between the ADC master and the MCP3202 responder
interface mcp3202_responder_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sck,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/mcp3202_responder.sv
// rtl/mcp3202_responder.sv - oversampled SPI slave emulating an MCP3202 12-bit dual-channel ADC
// Optional LSB-first tail (B1..B11 after B0 when MSBF=0) is built only with MCP3202_LSBF_EN defined.
module mcp3202_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  mcp3202_responder_if.slave  spi,
  input  logic [11:0]         ch0_sample,
  input  logic [11:0]         ch1_sample,
  output logic                conv_done,
  output logic [2:0]          last_cfg
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CFG,
    ST_NULL,
    ST_MSB_OUT,
    ST_LSB_OUT,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;

  // cs chain resets low so a master already holding cs_n low across reset does not look like a fresh fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = !cs_s && sck_s && !sck_d;
  assign sck_fall = !cs_s && !sck_s && sck_d;
  assign cs_fall  = !cs_s && cs_d;

  state_t      state, state_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic        sgl_q, sgl_nxt;
  logic        odd_q, odd_nxt;
  logic        msbf_q, msbf_nxt;
  logic [11:0] conv_q, conv_nxt;
  logic        miso_q, miso_nxt;
  logic        oe_q, oe_nxt;
  logic        done_q, done_nxt;
  logic [2:0]  cfg_q, cfg_nxt;

  logic [12:0] diff;
  logic [11:0] conv_sel;

  // Differential result is unsigned, so a negative 13-bit difference clamps to zero
  always_comb begin
    diff     = odd_q ? ({1'b0, ch1_sample} - {1'b0, ch0_sample})
                     : ({1'b0, ch0_sample} - {1'b0, ch1_sample});
    conv_sel = 12'd0;
    if (sgl_q)
      conv_sel = odd_q ? ch1_sample : ch0_sample;
    else if (!diff[12])
      conv_sel = diff[11:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      sgl_q   <= 1'b0;
      odd_q   <= 1'b0;
      msbf_q  <= 1'b0;
      conv_q  <= 12'd0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      cfg_q   <= 3'b000;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      sgl_q   <= sgl_nxt;
      odd_q   <= odd_nxt;
      msbf_q  <= msbf_nxt;
      conv_q  <= conv_nxt;
      miso_q  <= miso_nxt;
      oe_q    <= oe_nxt;
      done_q  <= done_nxt;
      cfg_q   <= cfg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sgl_nxt     = sgl_q;
    odd_nxt     = odd_q;
    msbf_nxt    = msbf_q;
    conv_nxt    = conv_q;
    miso_nxt    = miso_q;
    oe_nxt      = oe_q;
    done_nxt    = 1'b0;
    cfg_nxt     = cfg_q;

    // Deasserted chip select wins over any SCK edge seen in the same cycle
    if (cs_s) begin
      state_nxt = ST_IDLE;
      miso_nxt  = 1'b0;
      oe_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall)
            state_nxt = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (sck_rise && mosi_s) begin
            state_nxt   = ST_CFG;
            bit_cnt_nxt = 4'd0;
          end
        end
        ST_CFG: begin
          if (sck_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
            case (bit_cnt)
              4'd0:    sgl_nxt = mosi_s;
              4'd1:    odd_nxt = mosi_s;
              default: begin
                msbf_nxt  = mosi_s;
                cfg_nxt   = {sgl_q, odd_q, mosi_s};
                conv_nxt  = conv_sel;
                state_nxt = ST_NULL;
              end
            endcase
          end
        end
        ST_NULL: begin
          if (sck_fall) begin
            oe_nxt      = 1'b1;
            miso_nxt    = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = ST_MSB_OUT;
          end
        end
        ST_MSB_OUT: begin
          // bit_cnt counts bits already driven; 12 means B0 is on the wire
          if (sck_fall) begin
            if (bit_cnt != 4'd12) begin
              miso_nxt    = conv_q[4'd11 - bit_cnt];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end else begin
              done_nxt = 1'b1;
`ifdef MCP3202_LSBF_EN
              if (!msbf_q) begin
                miso_nxt    = conv_q[1];
                bit_cnt_nxt = 4'd2;
                state_nxt   = ST_LSB_OUT;
              end else begin
                miso_nxt  = 1'b0;
                oe_nxt    = 1'b0;
                state_nxt = ST_DONE;
              end
`else
              miso_nxt  = 1'b0;
              oe_nxt    = 1'b0;
              state_nxt = ST_DONE;
`endif
            end
          end
        end
`ifdef MCP3202_LSBF_EN
        ST_LSB_OUT: begin
          if (sck_fall) begin
            if (bit_cnt != 4'd12) begin
              miso_nxt    = conv_q[bit_cnt];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end else begin
              miso_nxt  = 1'b0;
              oe_nxt    = 1'b0;
              state_nxt = ST_DONE;
            end
          end
        end
`endif
        ST_DONE: begin
          miso_nxt = 1'b0;
        end
        default: begin
          state_nxt = ST_IDLE;
          miso_nxt  = 1'b0;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign conv_done       = done_q;
  assign last_cfg        = cfg_q;

endmodule

// File: tb/tb_mcp3202_responder.sv
// tb/tb_mcp3202_responder.sv - scoreboard bench for mcp3202_responder
module tb_mcp3202_responder;

  localparam int SYNC = 2;
  localparam int HALF = 16;
`ifdef MCP3202_LSBF_EN
  localparam bit LSBF = 1'b1;
`else
  localparam bit LSBF = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] conv;
    logic [2:0]  cfg;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [11:0] ch0_sample;
  logic [11:0] ch1_sample;
  logic        conv_done;
  logic [2:0]  last_cfg;

  mcp3202_responder_if spi_if ();

  mcp3202_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi        (spi_if),
    .ch0_sample (ch0_sample),
    .ch1_sample (ch1_sample),
    .conv_done  (conv_done),
    .last_cfg   (last_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int done_cnt = 0;
  always @(posedge clk) if (conv_done === 1'b1) done_cnt++;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] model_conv(input bit sgl, input bit odd,
                                              input logic [11:0] c0, input logic [11:0] c1);
    int d;
    if (sgl) return odd ? c1 : c0;
    d = odd ? (int'(c1) - int'(c0)) : (int'(c0) - int'(c1));
    return (d < 0) ? 12'd0 : 12'(d);
  endfunction

  task automatic spi_cycle(input logic mosi_bit, output logic miso_bit, output logic oe_bit);
    spi_if.spi_mosi = mosi_bit;
    wait_clks(HALF);
    miso_bit = spi_if.spi_miso;
    oe_bit   = spi_if.spi_miso_oe;
    spi_if.spi_sck = 1'b1;
    wait_clks(HALF);
    spi_if.spi_sck = 1'b0;
  endtask

  task automatic send_cmd(input int lead, input bit sgl, input bit odd, input bit msbf);
    logic b, o;
    spi_if.spi_cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < lead; i++) spi_cycle(1'b0, b, o);
    spi_cycle(1'b1, b, o);
    spi_cycle(sgl, b, o);
    spi_cycle(odd, b, o);
    spi_cycle(msbf, b, o);
  endtask

  task automatic run_frame(input string tag, input int lead, input bit sgl, input bit odd,
                           input bit msbf, input logic [11:0] c0, input logic [11:0] c1);
    logic        b, o, oe_all;
    logic [22:0] got;
    logic [10:0] exp_tail;
    exp_t        e;
    int          nbits, base;
    bit          tail;
    tail  = LSBF && !msbf;
    nbits = tail ? 23 : 12;
    ch0_sample = c0;
    ch1_sample = c1;
    sb_q.push_back('{conv: model_conv(sgl, odd, c0, c1), cfg: {sgl, odd, msbf}});
    base = done_cnt;
    send_cmd(lead, sgl, odd, msbf);
    ch0_sample = ~c0;
    ch1_sample = c1 ^ 12'h5A5;
    spi_cycle(1'b0, b, o);
    check_eq({tag, " null"}, b, 0);
    check_eq({tag, " null_oe"}, o, 1);
    got = '0;
    oe_all = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      spi_cycle(1'b0, b, o);
      got = {got[21:0], b};
      oe_all &= o;
    end
    wait_clks(SYNC + 3);
    e = sb_q.pop_front();
    check_eq({tag, " oe_during"}, oe_all, 1);
    check_eq({tag, " oe_end"}, spi_if.spi_miso_oe, 0);
    check_eq({tag, " done_cnt"}, done_cnt - base, 1);
    check_eq({tag, " last_cfg"}, last_cfg, e.cfg);
    if (tail) begin
      exp_tail = '0;
      for (int i = 1; i < 12; i++) exp_tail = {exp_tail[9:0], e.conv[i]};
      check_eq({tag, " msb_data"}, got[22:11], e.conv);
      check_eq({tag, " lsb_tail"}, got[10:0], exp_tail);
    end else begin
      check_eq({tag, " msb_data"}, got[11:0], e.conv);
    end
    spi_cycle(1'b1, b, o);
    spi_cycle(1'b1, b, o);
    wait_clks(SYNC + 3);
    check_eq({tag, " done_miso"}, {spi_if.spi_miso, spi_if.spi_miso_oe, b, o}, 0);
    check_eq({tag, " done_cnt2"}, done_cnt - base, 1);
    spi_if.spi_cs_n = 1'b1;
    wait_clks(HALF);
  endtask

  initial begin
    logic b, o;
    int   base;
    reset_n = 1'b0;
    spi_if.spi_sck  = 1'b0;
    spi_if.spi_cs_n = 1'b1;
    spi_if.spi_mosi = 1'b0;
    ch0_sample = 12'h000;
    ch1_sample = 12'h000;
    wait_clks(3);
    check_eq("rst outputs", {spi_if.spi_miso, spi_if.spi_miso_oe, conv_done, last_cfg}, 0);
    reset_n = 1'b1;
    wait_clks(HALF);

    run_frame("ch0", 0, 1'b1, 1'b0, 1'b1, 12'hA5C, 12'h3C3);
    run_frame("ch1_lead", 3, 1'b1, 1'b1, 1'b1, 12'hFFF, 12'h001);
    run_frame("diff_clamp", 0, 1'b0, 1'b0, 1'b1, 12'h100, 12'h300);
    run_frame("diff_odd", 0, 1'b0, 1'b1, 1'b1, 12'h100, 12'h300);
    run_frame("diff_pos", 1, 1'b0, 1'b0, 1'b1, 12'hC00, 12'h0FF);
    run_frame("lsbf", 0, 1'b1, 1'b0, 1'b0, 12'h801, 12'h000);
    run_frame("lsbf_rnd", 2, 1'b1, 1'b1, 1'b0, 12'h123, 12'($urandom_range(0, 4095)));

    ch0_sample = 12'hFFF;
    base = done_cnt;
    send_cmd(0, 1'b1, 1'b0, 1'b1);
    spi_cycle(1'b0, b, o);
    for (int i = 0; i < 5; i++) spi_cycle(1'b0, b, o);
    spi_if.spi_cs_n = 1'b1;
    wait_clks(SYNC + 2);
    check_eq("abort oe", spi_if.spi_miso_oe, 0);
    check_eq("abort miso", spi_if.spi_miso, 0);
    wait_clks(HALF);
    check_eq("abort done", done_cnt - base, 0);
    run_frame("post_abort", 0, 1'b1, 1'b1, 1'b1, 12'h000, 12'h7E3);

    base = done_cnt;
    send_cmd(0, 1'b1, 1'b1, 1'b1);
    spi_cycle(1'b0, b, o);
    for (int i = 0; i < 3; i++) spi_cycle(1'b0, b, o);
    wait_clks(4);
    reset_n = 1'b0;
    #1;
    check_eq("arst outputs", {spi_if.spi_miso, spi_if.spi_miso_oe, conv_done, last_cfg}, 0);
    wait_clks(3);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) spi_cycle(1'b1, b, o);
    wait_clks(SYNC + 3);
    check_eq("arst idle oe", spi_if.spi_miso_oe, 0);
    check_eq("arst idle cfg", last_cfg, 0);
    check_eq("arst done", done_cnt - base, 0);
    spi_if.spi_cs_n = 1'b1;
    wait_clks(HALF);
    run_frame("post_rst", 0, 1'b1, 1'b0, 1'b1, 12'h5A6, 12'h000);

    check_eq("sb empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
